parity_frame_tx: RTL and testbench

//   Serial frame transmitter. Drives the one-bit stream that the serial parity

---
 rtl/parity_frame_tx.sv | 108 ++++++++++
 tb/tb_parity_frame_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_tx
// Brief    : Serial frame transmitter. Sends one start bit, then WIDTH data
//            bits LSB first, then one parity bit. The line is low when idle.
// Revision : 1.0  initial release
// ============================================================================
module parity_frame_tx #(
    parameter int WIDTH = 8,
    parameter int ODD   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             serial_out,
    output logic             frame_out,
    output logic             last_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
    localparam logic             c_odd      = (ODD != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_DATA   = 2'd2,
        S_PARITY = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_parity;
    logic             w_parity_nxt;
    logic             w_serial_nxt;
    logic             w_accept;

    assign ready_out = (r_state == S_IDLE) || (r_state == S_PARITY);
    assign w_accept  = valid_in && ready_out;

    // Outputs are registered, so the next-state logic also decides the bit
    // that appears on the line during the next cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_cnt_nxt    = r_cnt;
        w_parity_nxt = r_parity;
        w_serial_nxt = 1'b0;
        case (r_state)
            S_IDLE, S_PARITY: begin
                if (w_accept) begin
                    w_state_nxt  = S_START;
                    w_shift_nxt  = data_in;
                    w_parity_nxt = (^data_in) ^ c_odd;
                    w_serial_nxt = 1'b1;
                end else begin
                    w_state_nxt  = S_IDLE;
                end
            end
            S_START: begin
                w_state_nxt  = S_DATA;
                w_cnt_nxt    = '0;
                w_serial_nxt = r_shift[0];
            end
            S_DATA: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt  = S_PARITY;
                    w_serial_nxt = r_parity;
                end else begin
                    w_cnt_nxt    = r_cnt + CNT_W'(1);
                    w_shift_nxt  = r_shift >> 1;
                    w_serial_nxt = w_shift_nxt[0];
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_parity   <= 1'b0;
            serial_out <= 1'b0;
            frame_out  <= 1'b0;
            last_out   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_parity   <= w_parity_nxt;
            serial_out <= w_serial_nxt;
            frame_out  <= (w_state_nxt != S_IDLE);
            last_out   <= (w_state_nxt == S_PARITY);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_parity_frame_tx
// Brief    : Directed bench for parity_frame_tx, even and odd parity builds.
// Revision : 1.0  initial release
// ============================================================================
module tb_parity_frame_tx;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] data_in  = 8'h00;
    logic       valid_in = 1'b0;

    logic ready_e, serial_e, frame_e, last_e;
    logic ready_o, serial_o, frame_o, last_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       par_even;
        logic       par_odd;
        logic       hold;
        logic       corrupt;
    } vec_t;

    vec_t vecs[4];

    parity_frame_tx #(.WIDTH(8), .ODD(0)) dut_even (
        .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_e), .serial_out(serial_e), .frame_out(frame_e), .last_out(last_e)
    );

    parity_frame_tx #(.WIDTH(8), .ODD(1)) dut_odd (
        .clock(clock), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_o), .serial_out(serial_o), .frame_out(frame_o), .last_out(last_o)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_serial"}, serial_e, 8'd0);
        chk({tag, "_frame"},  frame_e,  8'd0);
        chk({tag, "_last"},   last_e,   8'd0);
        chk({tag, "_ready"},  ready_e,  8'd1);
        chk({tag, "_serial_odd"}, serial_o, 8'd0);
        chk({tag, "_ready_odd"},  ready_o,  8'd1);
    endtask

    task automatic accept(input logic [7:0] w);
        chk("accept_ready", ready_e, 8'd1);
        valid_in = 1'b1;
        data_in  = w;
        tick();
    endtask

    // Checks the ten cycles of a frame that was accepted on the previous edge.
    task automatic run_frame(input vec_t v, input logic nv, input logic [7:0] nd);
        logic eb;
        logic ob;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                eb = 1'b1;
                ob = 1'b1;
            end else if (i == 9) begin
                eb = v.par_even;
                ob = v.par_odd;
            end else begin
                eb = v.data[i-1];
                ob = v.data[i-1];
            end
            chk($sformatf("serial_even_%02h_c%0d", v.data, i), serial_e, eb);
            chk($sformatf("serial_odd_%02h_c%0d", v.data, i), serial_o, ob);
            chk($sformatf("frame_%02h_c%0d", v.data, i), frame_e, 8'd1);
            chk($sformatf("last_%02h_c%0d", v.data, i), last_e, (i == 9) ? 8'd1 : 8'd0);
            chk($sformatf("ready_%02h_c%0d", v.data, i), ready_e, (i == 9) ? 8'd1 : 8'd0);
            if (i == 0) begin
                valid_in = v.hold;
                data_in  = v.corrupt ? ~v.data : v.data;
            end
            if (i == 9) begin
                valid_in = nv;
                data_in  = nd;
            end
            tick();
        end
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, par_even: 1'b0, par_odd: 1'b1, hold: 1'b0, corrupt: 1'b0};
        vecs[1] = '{data: 8'h07, par_even: 1'b1, par_odd: 1'b0, hold: 1'b0, corrupt: 1'b0};
        vecs[2] = '{data: 8'h3C, par_even: 1'b0, par_odd: 1'b1, hold: 1'b0, corrupt: 1'b1};
        vecs[3] = '{data: 8'h5B, par_even: 1'b1, par_odd: 1'b0, hold: 1'b1, corrupt: 1'b1};

        // Reset held for two cycles, then released.
        repeat (2) tick();
        chk_idle("in_reset");
        reset = 1'b0;
        tick();
        chk_idle("after_reset");

        for (int k = 0; k < 4; k++) begin
            accept(vecs[k].data);
            run_frame(vecs[k], 1'b0, 8'h00);
            chk_idle($sformatf("idle_after_%02h", vecs[k].data));
        end

        // Back-to-back: valid stays high, next word offered in the parity cycle.
        accept(8'h01);
        run_frame('{data: 8'h01, par_even: 1'b1, par_odd: 1'b0, hold: 1'b1, corrupt: 1'b0},
                  1'b1, 8'h80);
        run_frame('{data: 8'h80, par_even: 1'b1, par_odd: 1'b0, hold: 1'b0, corrupt: 1'b0},
                  1'b0, 8'h00);
        chk_idle("idle_after_b2b");

        // Reset during the fourth data bit of 8'hFF.
        accept(8'hFF);
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ff_serial_c%0d", i), serial_e, 8'd1);
            chk($sformatf("ff_frame_c%0d", i), frame_e, 8'd1);
            tick();
        end
        chk("ff_serial_c4", serial_e, 8'd1);
        reset = 1'b1;
        #1;
        chk_idle("async_reset");
        tick();
        chk_idle("reset_held");
        reset = 1'b0;
        accept(8'h3C);
        run_frame('{data: 8'h3C, par_even: 1'b0, par_odd: 1'b1, hold: 1'b0, corrupt: 1'b0},
                  1'b0, 8'h00);
        chk_idle("idle_after_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
